// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the double-dabble digit constants.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3_digit.sv
// Combinational double-dabble cell: adds 3 to a BCD digit that is >= 5
// so the following left shift carries correctly into the next digit.
module bcd_add3_digit
  import bin2bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Optional build macro BIN2BCD_RESTART_EN: start during SHIFT restarts the conversion.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int N       = 16,
  parameter int MAX_VAL = 9999
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     bcd_out,
  output logic             ovf
);

  localparam int               ACC_W    = N + DIGIT_W;
  localparam int               CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);

  if (N != DIGIT_W * DIGITS) begin : g_bad_width
    $error("bin2bcd_seq: N must equal 4*DIGITS");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [BIN_W-1:0] r_bin;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_pend;
  logic             r_acc_lost;
  logic             r_done;
  logic             r_ovf;
  logic [N-1:0]     r_bcd;
  logic [ACC_W-1:0] w_acc_adj;
  logic             w_accept;
  logic             w_ovf_final;

  for (genvar gi = 0; gi <= DIGITS; gi++) begin : g_add3
    bcd_add3_digit u_cell (
      .i_digit (r_acc[gi*DIGIT_W +: DIGIT_W]),
      .o_digit (w_acc_adj[gi*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BIN2BCD_RESTART_EN
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_SHIFT));
`else
  assign w_accept = start && (r_state == ST_IDLE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_accept)           w_state_next = ST_SHIFT;
        else if (r_cnt == '0)   w_state_next = ST_DONE;
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Accumulator MSB shifted out is kept sticky so an undersized accumulator reports overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_bin      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_acc_lost <= 1'b0;
    end else if (w_accept) begin
      r_acc      <= '0;
      r_bin      <= bin_in;
      r_cnt      <= CNT_LOAD;
      r_ovf_pend <= (bin_in > MAX_BIN);
      r_acc_lost <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_acc      <= {w_acc_adj[ACC_W-2:0], r_bin[BIN_W-1]};
      r_bin      <= r_bin << 1;
      r_cnt      <= r_cnt - 1'b1;
      r_acc_lost <= r_acc_lost | w_acc_adj[ACC_W-1];
    end
  end

  assign w_ovf_final = r_ovf_pend | r_acc_lost;

  // Results are published on the edge that leaves DONE, together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_ovf <= w_ovf_final;
        r_bcd <= w_ovf_final ? '1 : r_acc[N-1:0];
      end
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign bcd_out = r_bcd;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed, table-driven bench for bin2bcd_seq with hand-written multi-cycle sequences.
module tb_bin2bcd_seq;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        start  = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  bin2bcd_seq #(
    .BIN_W   (14),
    .DIGITS  (4),
    .N       (16),
    .MAX_VAL (9999)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One full conversion from IDLE; checks latency, busy length, result and pulse width.
  task automatic run_conv(input logic [13:0] val, input logic [15:0] exp_bcd,
                          input logic exp_ovf, input string tag);
    int lat;
    int busy_cnt;
    bit seen;
    lat      = 0;
    busy_cnt = 0;
    seen     = 0;
    @(negedge clk);
    bin_in = val;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        lat  = k;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    $display("conv %s: bin=%0d latency=%0d busy=%0d bcd=%04h ovf=%0b",
             tag, val, lat, busy_cnt, bcd_out, ovf);
    check($sformatf("%s_latency", tag), lat, 15);
    check($sformatf("%s_busy_cycles", tag), busy_cnt, 15);
    check($sformatf("%s_bcd", tag), {16'h0, bcd_out}, {16'h0, exp_bcd});
    check($sformatf("%s_ovf", tag), {31'h0, ovf}, {31'h0, exp_ovf});
    @(posedge clk);
    #1;
    check($sformatf("%s_done_width", tag), {31'h0, done}, 32'd0);
  endtask

  initial begin
    int          first_k;
    int          n_done;
    logic [15:0] first_bcd;
    int          cyc;
    bit          got;

    vecs[0] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
    vecs[1] = '{bin: 14'd291,   bcd: 16'h0291, ovf: 1'b0};
    vecs[2] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
    vecs[3] = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0};
    vecs[4] = '{bin: 14'd10000, bcd: 16'hFFFF, ovf: 1'b1};
    vecs[5] = '{bin: 14'd16383, bcd: 16'hFFFF, ovf: 1'b1};
    vecs[6] = '{bin: 14'd7,     bcd: 16'h0007, ovf: 1'b0};

    // Reset
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_done", {31'h0, done}, 32'd0);
    check("reset_bcd",  {16'h0, bcd_out}, 32'd0);
    check("reset_ovf",  {31'h0, ovf}, 32'd0);
    $display("reset: busy=%0b done=%0b bcd=%04h ovf=%0b", busy, done, bcd_out, ovf);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Second start pulse six edges into the conversion of 5
    first_k   = 0;
    n_done    = 0;
    first_bcd = '0;
    @(negedge clk);
    bin_in = 14'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (first_k == 0) begin
          first_k   = k;
          first_bcd = bcd_out;
        end
      end
      if (k == 5) begin
        bin_in = 14'd42;
        start  = 1'b1;
      end else if (k == 6) begin
        start = 1'b0;
      end
    end
    $display("restart: first_done_at=%0d bcd=%04h dones=%0d", first_k, first_bcd, n_done);
    check("restart_done_count", n_done, 1);
`ifdef BIN2BCD_RESTART_EN
    check("restart_done_time", first_k, 21);
    check("restart_bcd", {16'h0, first_bcd}, 32'h0042);
`else
    check("restart_done_time", first_k, 15);
    check("restart_bcd", {16'h0, first_bcd}, 32'h0005);
`endif

    // Asynchronous reset in the middle of converting 4321
    @(negedge clk);
    bin_in = 14'd4321;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("midreset: busy=%0b done=%0b bcd=%04h ovf=%0b", busy, done, bcd_out, ovf);
    check("midrst_busy", {31'h0, busy}, 32'd0);
    check("midrst_done", {31'h0, done}, 32'd0);
    check("midrst_bcd",  {16'h0, bcd_out}, 32'd0);
    check("midrst_ovf",  {31'h0, ovf}, 32'd0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    run_conv(14'd4321, 16'h4321, 1'b0, "post_rst");

    // start held high, bin_in stepped after each done
    @(negedge clk);
    bin_in = 14'd0;
    start  = 1'b1;
    for (int v = 0; v <= 20; v++) begin
      cyc = 0;
      got = 0;
      while (!got && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
        if (done) got = 1;
      end
      $display("stream: bin=%0d interval=%0d bcd=%04h ovf=%0b", v, cyc, bcd_out, ovf);
      check($sformatf("stream%0d_interval", v), cyc, 16);
      check($sformatf("stream%0d_bcd", v), {16'h0, bcd_out}, {16'h0, ref_bcd(v)});
      check($sformatf("stream%0d_ovf", v), {31'h0, ovf}, 32'd0);
      bin_in = 14'(v + 1);
    end
    start = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
